// File: rtl/req_pkg.sv
// Types shared between the ready/busy requester model and req_server.
package req_pkg;

  typedef enum {ready, busy} status;

  typedef enum {idle, serve, done} srv_state;

endpackage

// File: rtl/pend_counter.sv
// Saturating pending-request counter: accepts, drops and flags overflow.
module pend_counter #(
  parameter int unsigned PEND_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  input  logic              dec,
  output logic [PEND_W-1:0] count,
  output logic              full,
  output logic              overflow
);

  logic [PEND_W-1:0] count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              dec_ok;
  logic              acc;

  always_comb begin
    full   = (count_q == '1);
    dec_ok = dec && (count_q != '0);
    // A dequeue on the same edge frees a slot, so a full counter still accepts.
    acc    = inc && (!full || dec_ok);

    count_d = count_q;
    if (acc && !dec_ok) begin
      count_d = count_q + 1'b1;
    end else if (!acc && dec_ok) begin
      count_d = count_q - 1'b1;
    end

    overflow_d = overflow_q || (inc && full && !dec_ok);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: rtl/req_server.sv
// Queues incoming requests and services them one at a time for SERVICE_CYCLES cycles,
// pulsing grant once per completed request.
module req_server #(
  parameter int unsigned PEND_W         = 2,
  parameter int unsigned SERVICE_CYCLES = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              request,
  input  logic              stall,
  output logic              grant,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  import req_pkg::*;

  localparam int unsigned CntW = (SERVICE_CYCLES > 1) ? $clog2(SERVICE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(SERVICE_CYCLES - 1);

  srv_state        state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            deq;
  logic            full;

  assign deq = ((state_q == idle) || (state_q == done)) && (pending != '0);

  pend_counter #(
    .PEND_W (PEND_W)
  ) u_pend_counter (
    .clk      (clk),
    .reset    (reset),
    .inc      (request),
    .dec      (deq),
    .count    (pending),
    .full     (full),
    .overflow (overflow)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= idle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      idle: begin
        if (deq) begin
          state_d = serve;
          cnt_d   = CntLoad;
        end
      end
      serve: begin
        if (!stall) begin
          if (cnt_q == '0) begin
            state_d = done;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      done: begin
        // Chain straight into the next service so busy never drops between grants.
        if (deq) begin
          state_d = serve;
          cnt_d   = CntLoad;
        end else begin
          state_d = idle;
        end
      end
      default: state_d = idle;
    endcase
  end

  always_comb begin
    grant = (state_q == done);
    busy  = (state_q == serve) || (state_q == done);
  end

endmodule

// File: tb/tb_req_server.sv
// Directed bench for req_server: default parameters plus a SERVICE_CYCLES=1 instance.
module tb_req_server;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       request = 1'b0;
  logic       stall = 1'b0;
  logic       grant, busy, overflow;
  logic [1:0] pending;

  logic       req1 = 1'b0;
  logic       grant1, busy1, overflow1;
  logic [1:0] pending1;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  req_server #(
    .PEND_W         (2),
    .SERVICE_CYCLES (3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .request  (request),
    .stall    (stall),
    .grant    (grant),
    .busy     (busy),
    .pending  (pending),
    .overflow (overflow)
  );

  req_server #(
    .PEND_W         (2),
    .SERVICE_CYCLES (1)
  ) dut1 (
    .clk      (clk),
    .reset    (reset),
    .request  (req1),
    .stall    (1'b0),
    .grant    (grant1),
    .busy     (busy1),
    .pending  (pending1),
    .overflow (overflow1)
  );

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive inputs, take one rising edge, sample 1 ns later.
  task automatic step(input logic r, input logic s);
    request = r;
    stall   = s;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b0, 1'b0);
    reset = 1'b0;
  endtask

  // Continuous-request expectations after edges 1..26 (request high on edges 1..10).
  int pend_exp[26]  = '{1,1,2,3,3,3,3,3,3,3,3,3,3,2,2,2,2,1,1,1,1,0,0,0,0,0};
  int grant_exp[26] = '{0,0,0,0,1,0,0,0,1,0,0,0,1,0,0,0,1,0,0,0,1,0,0,0,1,0};
  int busy_exp[26]  = '{0,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,0};
  int ovf_exp[26]   = '{0,0,0,0,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1};

  initial begin
    // Reset state
    do_reset();
    check_eq("rst_grant", int'(grant), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_pending", int'(pending), 0);
    check_eq("rst_overflow", int'(overflow), 0);

    // Single request at edge 2
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    check_eq("single_e2_pending", int'(pending), 1);
    check_eq("single_e2_busy", int'(busy), 0);
    step(1'b0, 1'b0);
    check_eq("single_e3_pending", int'(pending), 0);
    check_eq("single_e3_busy", int'(busy), 1);
    check_eq("single_e3_grant", int'(grant), 0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check_eq("single_e5_busy", int'(busy), 1);
    check_eq("single_e5_grant", int'(grant), 0);
    step(1'b0, 1'b0);
    check_eq("single_e6_grant", int'(grant), 1);
    check_eq("single_e6_busy", int'(busy), 1);
    step(1'b0, 1'b0);
    check_eq("single_e7_grant", int'(grant), 0);
    check_eq("single_e7_busy", int'(busy), 0);

    // Continuous requests for 10 cycles
    do_reset();
    for (int e = 0; e < 26; e++) begin
      step(e < 10, 1'b0);
      check_eq($sformatf("cont_e%0d_pending", e + 1), int'(pending), pend_exp[e]);
      check_eq($sformatf("cont_e%0d_grant", e + 1), int'(grant), grant_exp[e]);
      check_eq($sformatf("cont_e%0d_busy", e + 1), int'(busy), busy_exp[e]);
      check_eq($sformatf("cont_e%0d_overflow", e + 1), int'(overflow), ovf_exp[e]);
    end

    // Full plus dequeue without prior overflow
    do_reset();
    for (int e = 0; e < 4; e++) step(1'b1, 1'b0);
    check_eq("fulldeq_e4_pending", int'(pending), 3);
    step(1'b0, 1'b0);
    check_eq("fulldeq_e5_grant", int'(grant), 1);
    check_eq("fulldeq_e5_pending", int'(pending), 3);
    step(1'b1, 1'b0);
    check_eq("fulldeq_e6_pending", int'(pending), 3);
    check_eq("fulldeq_e6_overflow", int'(overflow), 0);
    check_eq("fulldeq_e6_busy", int'(busy), 1);

    // Stall for 5 edges during serve: grant moves from edge 5 to edge 10
    do_reset();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check_eq("stall_e2_cnt", int'(dut.cnt_q), 2);
    for (int e = 0; e < 5; e++) begin
      step(1'b0, 1'b1);
      check_eq($sformatf("stall_hold%0d_cnt", e), int'(dut.cnt_q), 2);
      check_eq($sformatf("stall_hold%0d_grant", e), int'(grant), 0);
    end
    step(1'b0, 1'b0);
    check_eq("stall_e8_cnt", int'(dut.cnt_q), 1);
    step(1'b0, 1'b0);
    check_eq("stall_e9_cnt", int'(dut.cnt_q), 0);
    check_eq("stall_e9_grant", int'(grant), 0);
    step(1'b0, 1'b0);
    check_eq("stall_e10_grant", int'(grant), 1);
    step(1'b0, 1'b0);
    check_eq("stall_e11_grant", int'(grant), 0);

    // Reset mid-service with two pending; request on the reset edge is ignored
    do_reset();
    for (int e = 0; e < 3; e++) step(1'b1, 1'b0);
    check_eq("midrst_pre_pending", int'(pending), 2);
    check_eq("midrst_pre_busy", int'(busy), 1);
    reset = 1'b1;
    step(1'b1, 1'b0);
    reset = 1'b0;
    check_eq("midrst_grant", int'(grant), 0);
    check_eq("midrst_busy", int'(busy), 0);
    check_eq("midrst_pending", int'(pending), 0);
    check_eq("midrst_overflow", int'(overflow), 0);
    for (int e = 0; e < 6; e++) begin
      step(1'b0, 1'b0);
      check_eq($sformatf("midrst_after%0d_grant", e), int'(grant), 0);
      check_eq($sformatf("midrst_after%0d_busy", e), int'(busy), 0);
    end

    // SERVICE_CYCLES = 1: request at edge 1, grant after edge 3
    do_reset();
    req1 = 1'b1;
    step(1'b0, 1'b0);
    req1 = 1'b0;
    check_eq("sc1_e1_pending", int'(pending1), 1);
    step(1'b0, 1'b0);
    check_eq("sc1_e2_busy", int'(busy1), 1);
    check_eq("sc1_e2_grant", int'(grant1), 0);
    step(1'b0, 1'b0);
    check_eq("sc1_e3_grant", int'(grant1), 1);
    step(1'b0, 1'b0);
    check_eq("sc1_e4_grant", int'(grant1), 0);
    check_eq("sc1_e4_busy", int'(busy1), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
